// File: rtl/ahb_input_pkg.sv
// Shared definitions for the AHB-Lite input port sampler: register map,
// debounce FSM states and STATUS/CONFIG bit positions.
package ahb_input_pkg;

  // Word offsets as seen on HADDR[3:2]
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONFIG  = 2'd2;
  localparam logic [1:0] REG_CAPTURE = 2'd3;

  localparam int unsigned ST_CHANGED_BIT = 0;
  localparam int unsigned ST_OVERRUN_BIT = 1;
  localparam int unsigned CFG_DEB_MSB    = 15;
  localparam int unsigned CFG_IRQ_EN_BIT = 16;

  typedef enum logic {
    ST_STABLE,
    ST_SETTLE
  } deb_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus settle-count debouncer; pulses event_o on the
// cycle whose closing edge moves a new value into stable_o.
module input_debouncer
  import ahb_input_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  input  logic [15:0]      deb_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] cand_o,
  output logic             event_o
);

  deb_state_t       state_q, state_d;
  logic [WIDTH-1:0] s1_q, s_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [15:0]      cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s_q      <= '0;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      state_q  <= ST_STABLE;
    end else begin
      s1_q     <= raw_i;
      s_q      <= s1_q;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    event_o  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s_q != stable_q) begin
          cand_d  = s_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (s_q != cand_q) begin
          cand_d = s_q;
          cnt_d  = '0;
        end else if (cnt_q >= deb_i) begin
          // >= lets a lowered DEB finish at once instead of wrapping
          stable_d = cand_q;
          state_d  = ST_STABLE;
          event_o  = (cand_q != stable_q);
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  assign stable_o = stable_q;
  assign cand_o   = cand_q;

endmodule

// File: rtl/ahb_input_sampler.sv
// Zero-wait AHB-Lite slave exposing the debounced input port, change status,
// capture copy and a level interrupt.
module ahb_input_sampler
  import ahb_input_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter logic [15:0] DEB_RESET = 16'd1000
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [31:0]      HADDR,
  input  logic [31:0]      HWDATA,
  input  logic [2:0]       HSIZE,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HREADY,
  input  logic             HSEL,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  input  logic [WIDTH-1:0] iPort,
  output logic             irq
);

  logic             rd_en_q, wr_en_q;
  logic [1:0]       addr_q;
  logic [15:0]      deb_q, deb_d;
  logic             irq_en_q, irq_en_d;
  logic             changed_q, changed_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] stable, cand;
  logic             chg_event;
  logic             sel;
  logic [31:0]      stable_ext, capture_ext;
  logic             unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:17]};

  input_debouncer #(
    .WIDTH(WIDTH)
  ) u_deb (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .raw_i   (iPort),
    .deb_i   (deb_q),
    .stable_o(stable),
    .cand_o  (cand),
    .event_o (chg_event)
  );

  assign sel = HREADY & HSEL & (HTRANS != 2'b00);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      deb_q     <= DEB_RESET;
      irq_en_q  <= 1'b0;
      changed_q <= 1'b0;
      overrun_q <= 1'b0;
      capture_q <= '0;
    end else begin
      rd_en_q   <= sel & ~HWRITE;
      wr_en_q   <= sel & HWRITE;
      if (sel) addr_q <= HADDR[3:2];
      deb_q     <= deb_d;
      irq_en_q  <= irq_en_d;
      changed_q <= changed_d;
      overrun_q <= overrun_d;
      capture_q <= capture_d;
    end
  end

  always_comb begin
    deb_d     = deb_q;
    irq_en_d  = irq_en_q;
    changed_d = changed_q;
    overrun_d = overrun_q;
    capture_d = capture_q;
    if (wr_en_q && addr_q == REG_STATUS) begin
      changed_d = changed_q & ~HWDATA[ST_CHANGED_BIT];
      overrun_d = overrun_q & ~HWDATA[ST_OVERRUN_BIT];
    end
    if (wr_en_q && addr_q == REG_CONFIG) begin
      deb_d    = HWDATA[CFG_DEB_MSB:0];
      irq_en_d = HWDATA[CFG_IRQ_EN_BIT];
    end
    // Applied after the W1C so a same-cycle event wins over the clear
    if (chg_event) begin
      capture_d = cand;
      changed_d = 1'b1;
      if (changed_q) overrun_d = 1'b1;
    end
  end

  always_comb begin
    stable_ext  = '0;
    capture_ext = '0;
    stable_ext[WIDTH-1:0]  = stable;
    capture_ext[WIDTH-1:0] = capture_q;
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en_q) begin
      case (addr_q)
        REG_DATA:    HRDATA = stable_ext;
        REG_STATUS:  HRDATA = {30'd0, overrun_q, changed_q};
        REG_CONFIG:  HRDATA = {15'd0, irq_en_q, deb_q};
        REG_CAPTURE: HRDATA = capture_ext;
        default:     HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign irq       = changed_q & irq_en_q;

endmodule

// File: tb/tb_ahb_input_sampler.sv
// Self-checking bench: run-length reference model of the debounced port plus
// register model, compared on every falling edge, with directed literal pins.
module tb_ahb_input_sampler;

  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CONFIG = 2'd2, A_CAPTURE = 2'd3;

  logic        HCLK, HRESET;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HSEL, HREADYOUT, irq;
  logic [31:0] iPort;

  int total = 0;
  int bad   = 0;

  ahb_input_sampler #(
    .WIDTH(32),
    .DEB_RESET(16'd1000)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .iPort(iPort), .irq(irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: the synchronised value must be seen unchanged on
  // DEB+2 consecutive edges before it becomes the stable value.
  logic [31:0] m_s1, m_s, m_prev, m_stable, m_cap;
  int unsigned m_run;
  logic        m_chg, m_ovr, m_irqen, m_ev, m_old_chg;
  logic [15:0] m_deb;
  logic        m_dp_rd, m_dp_wr;
  logic [1:0]  m_dp_addr;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m_s1 = '0; m_s = '0; m_prev = '0; m_stable = '0; m_cap = '0; m_run = 0;
      m_chg = 0; m_ovr = 0; m_irqen = 0; m_deb = 16'd1000;
      m_dp_rd = 0; m_dp_wr = 0; m_dp_addr = '0;
    end else begin
      if (m_s == m_prev) begin
        if (m_run != 32'hFFFF_FFFF) m_run = m_run + 1;
      end else begin
        m_run = 1;
      end
      m_prev    = m_s;
      m_ev      = (m_s != m_stable) && (m_run >= 32'(m_deb) + 2);
      m_old_chg = m_chg;
      if (m_dp_wr && m_dp_addr == A_STATUS) begin
        if (HWDATA[0]) m_chg = 0;
        if (HWDATA[1]) m_ovr = 0;
      end
      if (m_dp_wr && m_dp_addr == A_CONFIG) begin
        m_deb   = HWDATA[15:0];
        m_irqen = HWDATA[16];
      end
      if (m_ev) begin
        m_stable = m_s;
        m_cap    = m_s;
        if (m_old_chg) m_ovr = 1;
        m_chg = 1;
      end
      m_s  = m_s1;
      m_s1 = iPort;
      m_dp_rd = HSEL && HREADY && (HTRANS != 2'b00) && !HWRITE;
      m_dp_wr = HSEL && HREADY && (HTRANS != 2'b00) && HWRITE;
      if (HSEL && HREADY && (HTRANS != 2'b00)) m_dp_addr = HADDR[3:2];
    end
  end

  logic [31:0] exp_rd;
  always @(negedge HCLK) begin
    exp_rd = '0;
    if (m_dp_rd) begin
      case (m_dp_addr)
        A_DATA:    exp_rd = m_stable;
        A_STATUS:  exp_rd = {30'd0, m_ovr, m_chg};
        A_CONFIG:  exp_rd = {15'd0, m_irqen, m_deb};
        default:   exp_rd = m_cap;
      endcase
    end
    check("hrdata", HRDATA, exp_rd);
    check("irq", {31'd0, irq}, {31'd0, m_chg & m_irqen});
    check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, a, 2'b00};
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, a, 2'b00};
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = v;
  endtask

  logic [31:0] r, wd;
  logic [1:0]  wa;
  int          n;
  int unsigned act;

  initial begin
    HRESET = 1'b0; HADDR = '0; HWDATA = '0; HSIZE = 3'b010; HTRANS = 2'b00;
    HWRITE = 1'b0; HREADY = 1'b1; HSEL = 1'b0; iPort = '0;
    #2 HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Reset defaults
    bus_read(A_CONFIG, r);  check("cfg_reset", r, 32'h0000_03E8);
    bus_read(A_STATUS, r);  check("status_reset", r, 32'd0);
    check("irq_reset", {31'd0, irq}, 32'd0);

    // Clean change, DEB=5: capture edge k, stable from edge k+8
    bus_write(A_CONFIG, 32'd5);
    tick(2);
    iPort = 32'hA5;
    tick(7);
    bus_read(A_DATA, r);    check("clean_k7", r, 32'd0);
    bus_read(A_DATA, r);    check("clean_k8", r, 32'hA5);
    bus_read(A_CAPTURE, r); check("clean_capture", r, 32'hA5);
    bus_read(A_STATUS, r);  check("clean_status", r, 32'd1);
    check("clean_irq_off", {31'd0, irq}, 32'd0);

    // Overrun then W1C
    iPort = 32'h5A;
    tick(12);
    bus_read(A_STATUS, r);  check("overrun_status", r, 32'd3);
    bus_read(A_DATA, r);    check("overrun_data", r, 32'h5A);
    bus_write(A_STATUS, 32'd3);
    bus_read(A_STATUS, r);  check("w1c_status", r, 32'd0);

    // Back to 0, then bounce with DEB=10 and interrupts on
    iPort = 32'd0;
    tick(12);
    bus_write(A_STATUS, 32'd3);
    bus_write(A_CONFIG, 32'h0001_000A);
    bus_read(A_STATUS, r);  check("pre_bounce_status", r, 32'd0);
    for (int i = 0; i < 10; i++) begin
      iPort = (i % 2 == 0) ? 32'd1 : 32'd0;
      tick(4);
    end
    check("bounce_quiet", {31'd0, irq}, 32'd0);
    iPort = 32'd1;
    n = 0;
    while (irq == 1'b0 && n < 100) begin
      tick(1);
      n++;
    end
    check("bounce_latency", 32'(n), 32'd14);
    tick(20);
    bus_read(A_STATUS, r);  check("bounce_one_event", r, 32'd1);
    bus_read(A_DATA, r);    check("bounce_data", r, 32'd1);

    // W1C of CHANGED lands on the event edge; set wins
    bus_write(A_CONFIG, 32'h0001_0005);
    tick(3);
    iPort = 32'd0;
    tick(7);
    bus_write(A_STATUS, 32'd1);
    tick(1);
    bus_read(A_STATUS, r);  check("set_beats_clear", r, 32'd3);
    check("set_beats_clear_irq", {31'd0, irq}, 32'd1);

    // DEB lowered mid-settle completes on the following edge
    bus_write(A_STATUS, 32'd3);
    bus_write(A_CONFIG, 32'h0001_03E8);
    bus_read(A_STATUS, r);  check("pre_lower_status", r, 32'd0);
    tick(1);
    iPort = 32'h77;
    tick(52);
    bus_write(A_CONFIG, 32'h0001_000A);
    tick(1);
    check("lower_deb_write_edge", {31'd0, irq}, 32'd0);
    tick(1);
    check("lower_deb_next_edge", {31'd0, irq}, 32'd1);
    bus_read(A_DATA, r);    check("lower_deb_data", r, 32'h77);

    // Reset mid-settle aborts without an event; input then re-settles
    iPort = 32'h33;
    tick(20);
    HRESET = 1'b1;
    tick(2);
    HRESET = 1'b0;
    bus_read(A_DATA, r);    check("rst_mid_data", r, 32'd0);
    bus_read(A_STATUS, r);  check("rst_mid_status", r, 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    tick(1010);
    bus_read(A_STATUS, r);  check("post_rst_status", r, 32'd1);
    bus_read(A_DATA, r);    check("post_rst_data", r, 32'h33);

    // Randomised traffic against the model
    bus_write(A_CONFIG, 32'h0001_0003);
    bus_write(A_STATUS, 32'd3);
    for (int i = 0; i < 400; i++) begin
      act = $urandom_range(0, 9);
      if (act < 4) begin
        iPort = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
        tick($urandom_range(1, 10));
      end else if (act < 7) begin
        bus_read(2'($urandom_range(0, 3)), r);
      end else if (act < 9) begin
        wa = 2'($urandom_range(0, 3));
        wd = $urandom;
        if (wa == A_CONFIG) wd = {wd[31:17], wd[16], 16'($urandom_range(0, 6))};
        bus_write(wa, wd);
      end else begin
        tick(1);
      end
    end
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_input_sampler.md
# ahb_input_sampler

AHB-Lite slave that owns the off-chip input port for the M0 system. It synchronises and debounces the raw `iPort` word and presents the stable value to software. It also detects changes, latches a capture copy and raises an interrupt. It runs zero-wait-state on the same AHB-Lite bus as the other system slaves and replaces direct, unfiltered reads of the port.

## Interface
- `WIDTH`, 32: width of `iPort`, 1..32; unused read bits return 0.
- `DEB_RESET`, 16'd1000: reset value of the debounce count field `CONFIG[15:0]`.

Ports:
- `HCLK`  in  1  system clock; the only clock.
- `HRESET`  in  1  reset, asynchronous, active-high.
- `HADDR`  in  32  address; only `[3:2]` decoded.
- `HWDATA`  in  32  write data, sampled in the data phase.
- `HSIZE`  in  3  ignored; word access only.
- `HTRANS`  in  2  transfer type; `2'b00` (IDLE) means no transfer.
- `HWRITE`  in  1  1 = write.
- `HREADY`  in  1  bus ready.
- `HSEL`  in  1  slave select.
- `HRDATA`  out  32  read data, data phase.
- `HREADYOUT`  out  1  tied to 1.
- `iPort`  in  WIDTH  raw asynchronous input.
- `irq`  out  1  level interrupt: `CHANGED & IRQ_EN`.

## Operation
- **Address phase:** when `HREADY & HSEL & HTRANS != IDLE`, register `rd_en`, `wr_en` and `HADDR[3:2]`. Otherwise clear `rd_en` and `wr_en`.
- **Register map:**
  - 0x0 DATA (RO): debounced stable value.
  - 0x4 STATUS: bit0 CHANGED, bit1 OVERRUN. Write-1-to-clear. Reads do not clear.
  - 0x8 CONFIG (RW): `[15:0]` DEB, bit16 IRQ_EN. Other bits read 0.
  - 0xC CAPTURE (RO): copy of `stable` taken at the last change event.
- **Read data:** `HRDATA` is 0 when `rd_en` = 0. Writes to RO offsets are ignored.
- **Synchroniser:** two flops, `iPort` → `s1` → `s`.
- **Debounce FSM:** state `ST_STABLE` / `ST_SETTLE`; 16-bit counter `cnt`; candidate register `cand`.
  - `ST_STABLE`: if `s != stable`, then `cand <= s`, `cnt <= 0`, go to `ST_SETTLE`.
  - `ST_SETTLE`, first matching condition wins:
    - `s != cand`: `cand <= s`, `cnt <= 0`; stay in `ST_SETTLE`.
    - `cnt >= DEB`: `stable <= cand`, go to `ST_STABLE`. If `cand != stable`, this is a change event.
    - otherwise `cnt <= cnt + 1` (saturating).
  - The compare uses `>=`, so a CONFIG write that lowers DEB mid-settle completes on the next cycle with no wrap.
- **Change event:** `CAPTURE <= cand`; set CHANGED. If CHANGED is already 1, also set OVERRUN.
- **Simultaneous event and W1C clear of the same bit:** set wins.

## Timing
- Reset values:
  - `HRDATA` 0, `HREADYOUT` 1, `irq` 0.
  - `s1`, `s`, `stable`, `cand`, CAPTURE: 0.
  - `cnt` 0, state `ST_STABLE`.
  - CONFIG = `{IRQ_EN=0, DEB=DEB_RESET}`; STATUS 0.
- A nonzero `iPort` at reset release produces a change event after debounce.
- Latency: new value first captured in `s1` at edge k → `stable`, CAPTURE and CHANGED update at edge k+3+DEB. `irq` follows CHANGED in the same cycle.
- A bounce (`s != cand`) at any point restarts the count; `stable` is unchanged.
- A glitch shorter than DEB+1 cycles that returns to the `stable` value produces no event.
- Bus reads are zero-wait. DATA reflects `stable` as of the end of the address-phase cycle, i.e. the value registered on the edge ending the address phase.
- Register writes take effect on the edge ending the data phase.
- Asserting `HRESET` mid-settle aborts the settle immediately (async); no event is generated.

## Structure
- Package `ahb_input_pkg`:
  - register offset localparams `REG_DATA`, `REG_STATUS`, `REG_CONFIG`, `REG_CAPTURE`;
  - enum `deb_state_t {ST_STABLE, ST_SETTLE}`;
  - STATUS and CONFIG bit-position constants.
- One sub-module, `input_debouncer`, containing:
  - inputs: `raw`, `deb`;
  - outputs: `stable`, `event`;
  - the synchroniser, the FSM and `cnt`.
- The top level holds the AHB decode and the STATUS, CONFIG and CAPTURE registers.

## Test plan
- **Reset defaults:** reset, read CONFIG → `0x0000_03E8`; read STATUS → 0; `irq` = 0; `HREADYOUT` = 1 throughout.
- **Clean change:** DEB=5, `iPort`: 0 → `0xA5` at edge k → DATA = `0xA5` from edge k+8; CAPTURE = `0xA5`; STATUS = 1; `irq` = 0 while IRQ_EN = 0.
- **Bounce:** DEB=10, `iPort` toggles `0x1`/`0x0` every 4 cycles for 40 cycles then holds `0x1` → exactly one event, 13 cycles after the last toggle.
- **Overrun, then W1C:** two separate changes with no clear → STATUS = 3. Write `0x3` to STATUS → STATUS = 0.
- **Set beats clear:** W1C of CHANGED issued in the same cycle as an event → CHANGED stays 1.
- **DEB lowered mid-settle, then reset:**
  - DEB=1000; after 50 settle cycles write DEB=10 → `stable` updates on the next edge.
  - Assert `HRESET` mid-settle → DATA = 0, no event.
